// File: rtl/soc_sysid_pkg.sv
// Shared types and constants for the system ID / build timestamp checker.
// Word addresses and default expectations match the SoC system-ID peripheral layout.
package soc_sysid_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRdId,
      StRdTs,
      StCheck,
      StFin
   } state_e;

   localparam logic        ID_WORD = 1'b0;
   localparam logic        TS_WORD = 1'b1;

   localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
   localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1668877045;

   localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/soc_sysid_checker_if.sv
// Avalon-MM read-only bus used by the system ID checker.
// The master issues reads; the slave stalls with waitrequest and returns readdata.
interface soc_sysid_checker_if;

   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_waitrequest,
      input  avm_readdata
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_waitrequest,
      output avm_readdata
   );

endinterface

// File: rtl/soc_sysid_checker.sv
// Reads the system ID and build timestamp over Avalon-MM and compares them with the
// expected values; a stalled read longer than TIMEOUT_CYCLES aborts the sequence.
module soc_sysid_checker
   import soc_sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
   parameter int unsigned TIMEOUT_CYCLES     = 255
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       start,
   soc_sysid_checker_if.master        avm,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic [31:0]                id_value,
   output logic [31:0]                ts_value,
   output logic                       err_id,
   output logic                       err_ts,
   output logic                       err_timeout
);

   localparam logic [CNT_W-1:0] TimeoutLim = CNT_W'(TIMEOUT_CYCLES);

   state_e           state_q;
   logic             read_q;
   logic             addr_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic             err_id_q;
   logic             err_ts_q;
   logic             err_to_q;
   logic [31:0]      id_q;
   logic [31:0]      ts_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc;

   assign cnt_inc = cnt_q + 1'b1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         read_q   <= 1'b0;
         addr_q   <= ID_WORD;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_id_q <= 1'b0;
         err_ts_q <= 1'b0;
         err_to_q <= 1'b0;
         id_q     <= '0;
         ts_q     <= '0;
         cnt_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q  <= StRdId;
                  read_q   <= 1'b1;
                  addr_q   <= ID_WORD;
                  busy_q   <= 1'b1;
                  done_q   <= 1'b0;
                  pass_q   <= 1'b0;
                  err_id_q <= 1'b0;
                  err_ts_q <= 1'b0;
                  err_to_q <= 1'b0;
                  cnt_q    <= '0;
               end
            end
            StRdId, StRdTs: begin
               // Completion is tested first so data arriving on the limit cycle wins.
               if (!avm.avm_waitrequest) begin
                  cnt_q <= '0;
                  if (state_q == StRdId) begin
                     id_q    <= avm.avm_readdata;
                     addr_q  <= TS_WORD;
                     state_q <= StRdTs;
                  end else begin
                     ts_q    <= avm.avm_readdata;
                     read_q  <= 1'b0;
                     state_q <= StCheck;
                  end
               end else if (cnt_inc == TimeoutLim) begin
                  cnt_q    <= cnt_inc;
                  read_q   <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  err_to_q <= 1'b1;
                  state_q  <= StFin;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            StCheck: begin
               err_id_q <= (id_q != EXPECTED_ID);
               err_ts_q <= (ts_q != EXPECTED_TIMESTAMP);
               pass_q   <= (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TIMESTAMP);
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= StFin;
            end
            StFin: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign avm.avm_read    = read_q;
   assign avm.avm_address = addr_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign id_value        = id_q;
   assign ts_value        = ts_q;
   assign err_id          = err_id_q;
   assign err_ts          = err_ts_q;
   assign err_timeout     = err_to_q;

endmodule

// File: tb/tb_soc_sysid_checker.sv
// Bench for soc_sysid_checker: a cycle-timeline model derived from stall counts predicts
// every output each cycle; directed sequences add hand-computed literal expectations.
module tb_soc_sysid_checker;

   localparam int          T      = 8;
   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1668877045;
   localparam int          STUCK  = 1000;

   typedef struct packed {
      logic        read;
      logic        addr;
      logic        busy;
      logic        done;
      logic        pass;
      logic        err_id;
      logic        err_ts;
      logic        err_to;
      logic [31:0] id;
      logic [31:0] ts;
   } outs_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        busy, done, pass, err_id, err_ts, err_timeout;
   logic [31:0] id_value, ts_value;

   soc_sysid_checker_if bus ();

   soc_sysid_checker #(
      .EXPECTED_ID        (EXP_ID),
      .EXPECTED_TIMESTAMP (EXP_TS),
      .TIMEOUT_CYCLES     (T)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .avm         (bus.master),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .id_value    (id_value),
      .ts_value    (ts_value),
      .err_id      (err_id),
      .err_ts      (err_ts),
      .err_timeout (err_timeout)
   );

   always #5 clock = ~clock;

   // Slave: stalls each read for cfg_s* cycles, then returns cfg_d*.
   int          cfg_s0 = 0, cfg_s1 = 0;
   logic [31:0] cfg_d0 = EXP_ID, cfg_d1 = EXP_TS;
   int          stall_seen = 0;
   int          rd_count = 0;

   always_comb begin
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdata    = bus.avm_address ? cfg_d1 : cfg_d0;
      if (bus.avm_read) bus.avm_waitrequest = (stall_seen < (bus.avm_address ? cfg_s1 : cfg_s0));
   end

   always @(posedge clock) begin
      if (!bus.avm_read || !bus.avm_waitrequest) stall_seen <= 0;
      else stall_seen <= stall_seen + 1;
      if (bus.avm_read && !bus.avm_waitrequest) rd_count <= rd_count + 1;
   end

   // Model: k = cycles since the accepting edge; the timeline follows from stall counts.
   function automatic int fin_k(input int s0, input int s1);
      if (s0 >= T) return T + 1;
      if (s1 >= T) return 2 + s0 + T;
      return 4 + s0 + s1;
   endfunction

   function automatic outs_t predict(input bit v, input int k, input int s0, input int s1,
                                     input logic [31:0] d0, input logic [31:0] d1,
                                     input logic [31:0] bid, input logic [31:0] bts);
      outs_t o;
      int    w0_end;
      int    w1_end;
      o    = '0;
      o.id = bid;
      o.ts = bts;
      if (!v) return o;
      w0_end = (s0 >= T) ? T : 1 + s0;
      if (k <= w0_end) begin
         o.read = 1'b1; o.addr = 1'b0; o.busy = 1'b1;
         return o;
      end
      if (s0 >= T) begin
         o.done = 1'b1; o.err_to = 1'b1;
         return o;
      end
      o.id   = d0;
      w1_end = (s1 >= T) ? 1 + s0 + T : 2 + s0 + s1;
      if (k <= w1_end) begin
         o.read = 1'b1; o.addr = 1'b1; o.busy = 1'b1;
         return o;
      end
      if (s1 >= T) begin
         o.done = 1'b1; o.err_to = 1'b1;
         return o;
      end
      o.ts = d1;
      if (k == w1_end + 1) begin
         o.busy = 1'b1;
         return o;
      end
      o.done   = 1'b1;
      o.err_id = (d0 != EXP_ID);
      o.err_ts = (d1 != EXP_TS);
      o.pass   = (d0 == EXP_ID) && (d1 == EXP_TS);
      return o;
   endfunction

   bit          m_valid;
   int          m_k, m_s0, m_s1;
   logic [31:0] m_d0, m_d1, m_bid, m_bts;
   outs_t       exp_now;

   always_comb exp_now = predict(m_valid, m_k, m_s0, m_s1, m_d0, m_d1, m_bid, m_bts);

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_valid <= 1'b0; m_k <= 0; m_s0 <= 0; m_s1 <= 0;
         m_d0 <= '0; m_d1 <= '0; m_bid <= '0; m_bts <= '0;
      end else if (start && (!m_valid || m_k > fin_k(m_s0, m_s1))) begin
         m_valid <= 1'b1; m_k <= 1; m_s0 <= cfg_s0; m_s1 <= cfg_s1;
         m_d0 <= cfg_d0; m_d1 <= cfg_d1; m_bid <= exp_now.id; m_bts <= exp_now.ts;
      end else if (m_valid && m_k < 1000000) begin
         m_k <= m_k + 1;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      chk("avm_read", 32'(bus.avm_read), 32'(exp_now.read));
      if (exp_now.read) chk("avm_address", 32'(bus.avm_address), 32'(exp_now.addr));
      chk("busy", 32'(busy), 32'(exp_now.busy));
      chk("done", 32'(done), 32'(exp_now.done));
      chk("pass", 32'(pass), 32'(exp_now.pass));
      chk("err_id", 32'(err_id), 32'(exp_now.err_id));
      chk("err_ts", 32'(err_ts), 32'(exp_now.err_ts));
      chk("err_timeout", 32'(err_timeout), 32'(exp_now.err_to));
      chk("id_value", id_value, exp_now.id);
      chk("ts_value", ts_value, exp_now.ts);
   endtask

   task automatic tick();
      @(negedge clock);
      if (cmp_en) compare_model();
   endtask

   // Pulses start from idle and returns at the first cycle with done=1.
   task automatic run_seq(input int s0, input int s1, input logic [31:0] d0,
                          input logic [31:0] d1, output int rd_cyc, output int lat);
      bit seen;
      cfg_s0 = s0; cfg_s1 = s1; cfg_d0 = d0; cfg_d1 = d1;
      rd_cyc = 0; lat = 0; seen = 1'b0;
      tick();
      start = 1'b1;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick();
         start = 1'b0;
         if (bus.avm_read) rd_cyc++;
         if (done) begin
            seen = 1'b1;
            lat  = i + 1;
         end
      end
      if (!seen) chk("done_wait", 32'd0, 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int rc, lat, rd0;
      reset_n = 1'b0;
      start   = 1'b0;
      @(posedge clock);
      cmp_en = 1'b1;
      tick();
      chk("rst_avm_read", 32'(bus.avm_read), 32'd0);
      chk("rst_avm_address", 32'(bus.avm_address), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_id_value", id_value, 32'd0);
      tick();
      reset_n = 1'b1;

      // Zero-wait, matching words.
      run_seq(0, 0, EXP_ID, EXP_TS, rc, lat);
      chk("lat_zero_wait", 32'(lat), 32'd4);
      chk("pass_zero_wait", 32'(pass), 32'd1);
      chk("ts_zero_wait", ts_value, 32'd1668877045);
      chk("rd_cyc_zero_wait", 32'(rc), 32'd2);

      // ID mismatch.
      run_seq(0, 0, 32'h0000_0001, EXP_TS, rc, lat);
      chk("err_id_mism", 32'(err_id), 32'd1);
      chk("err_ts_mism", 32'(err_ts), 32'd0);
      chk("pass_id_mism", 32'(pass), 32'd0);
      chk("id_value_mism", id_value, 32'd1);

      // Timestamp mismatch in the top bit only.
      run_seq(0, 0, EXP_ID, EXP_TS ^ 32'h8000_0000, rc, lat);
      chk("err_ts_top", 32'(err_ts), 32'd1);
      chk("pass_ts_top", 32'(pass), 32'd0);

      // Three stall cycles on word 1.
      run_seq(0, 3, EXP_ID, EXP_TS, rc, lat);
      chk("rd_cyc_ws3", 32'(rc), 32'd5);
      chk("lat_ws3", 32'(lat), 32'd7);
      chk("pass_ws3", 32'(pass), 32'd1);

      // One stall short of the limit on both words still completes.
      run_seq(T - 1, T - 1, EXP_ID, EXP_TS, rc, lat);
      chk("lat_limit_minus1", 32'(lat), 32'd18);
      chk("pass_limit_minus1", 32'(pass), 32'd1);
      chk("err_to_limit_minus1", 32'(err_timeout), 32'd0);

      // Word 0 stuck: read held for exactly T cycles, then abort.
      run_seq(STUCK, 0, 32'h1234_5678, EXP_TS, rc, lat);
      chk("rd_cyc_to0", 32'(rc), 32'd8);
      chk("lat_to0", 32'(lat), 32'd9);
      chk("err_timeout_to0", 32'(err_timeout), 32'd1);
      chk("pass_to0", 32'(pass), 32'd0);
      chk("err_id_to0", 32'(err_id), 32'd0);

      // Word 1 stuck: word 0 already captured.
      run_seq(0, STUCK, 32'h0000_00a5, EXP_TS, rc, lat);
      chk("lat_to1", 32'(lat), 32'd10);
      chk("id_value_to1", id_value, 32'h0000_00a5);
      chk("err_timeout_to1", 32'(err_timeout), 32'd1);
      chk("err_ts_to1", 32'(err_ts), 32'd0);

      run_seq(0, 0, EXP_ID, EXP_TS, rc, lat);
      chk("pass_before_reset", 32'(pass), 32'd1);

      // Reset asserted mid-way through the word 1 read.
      cfg_s0 = 0; cfg_s1 = 3; cfg_d0 = EXP_ID; cfg_d1 = 32'hdead_beef;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("in_rd_ts_read", 32'(bus.avm_read), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_read", 32'(bus.avm_read), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_done", 32'(done), 32'd0);
      chk("async_rst_ts", ts_value, 32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      run_seq(0, 0, EXP_ID, EXP_TS, rc, lat);
      chk("lat_after_reset", 32'(lat), 32'd4);
      chk("pass_after_reset", 32'(pass), 32'd1);

      // Start pulses during RD_ID and during FIN are ignored.
      cfg_s0 = 2; cfg_s1 = 0; cfg_d0 = EXP_ID; cfg_d1 = EXP_TS;
      rd0 = rd_count;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20 && !done; i++) tick();
      chk("ign_done_seen", 32'(done), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("ign_busy", 32'(busy), 32'd0);
      chk("ign_done_held", 32'(done), 32'd1);
      chk("ign_bus_reads", 32'(rd_count - rd0), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
